// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO controller: register offsets, STATUS bit
// positions and the TX sequencer state encoding.
package uart_pkg;

    localparam int REG_TXDATA = 'h0;
    localparam int REG_RXDATA = 'h4;
    localparam int REG_STATUS = 'h8;
    localparam int REG_CTRL   = 'hC;

    localparam int ST_TXFULL = 0;
    localparam int ST_RXNE   = 1;
    localparam int ST_TXE    = 2;
    localparam int ST_TXOVF  = 3;
    localparam int ST_RXOVF  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// CPU-side register bus: single-cycle read/write strobes, read data one cycle later.
interface uart_mmio_ctrl_if #(parameter int ADDR_W = 4);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              we;
    logic              re;
    logic [31:0]       rdata;
    logic              rvalid;

    modport master (output addr, wdata, we, re, input rdata, rvalid);
    modport slave  (input addr, wdata, we, re, output rdata, rvalid);
endinterface

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock show-ahead FIFO. A push while full is accepted only if a pop
// frees the slot in the same cycle; a pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the uart block: TX/RX FIFOs, byte sequencer, status/irq.
//   state     | meaning
//   IDLE      | waiting for a TX byte; pops the FIFO head into uart_tx_data
//   LOAD      | raise send for the latched byte
//   WAIT_BUSY | hold send and data until the uart reports busy
//   WAIT_DONE | send low, wait for busy to fall
module uart_mmio_ctrl
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_mmio_ctrl_if.slave       bus,
    output logic                  uart_send,
    output logic [7:0]            uart_tx_data,
    input  logic                  uart_busy,
    input  logic [7:0]            uart_rx_data,
    input  logic                  uart_rx_rdy,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t         state, state_nx;
    logic              tx_pop, tx_full, tx_empty;
    logic [7:0]        tx_dout, rx_dout;
    logic              rx_full, rx_empty, rx_edge, rx_pop, rx_rdy_q;
    logic [CW-1:0]     tx_count, rx_count;
    logic [1:0]        ctrl;
    logic              txovf, rxovf, txovf_set, rxovf_set;
    logic              txe, rxne;
    logic [4:0]        status;
    logic [ADDR_W-1:0] word_addr;
    logic              wr_tx, wr_status, wr_ctrl;
    logic [31:0]       rd_mux;
    logic              unused_ok;

    assign word_addr = {bus.addr[ADDR_W-1:2], 2'b00};
    assign wr_tx     = bus.we & (word_addr == ADDR_W'(REG_TXDATA));
    assign wr_status = bus.we & (word_addr == ADDR_W'(REG_STATUS));
    assign wr_ctrl   = bus.we & (word_addr == ADDR_W'(REG_CTRL));
    assign rx_pop    = bus.re & (word_addr == ADDR_W'(REG_RXDATA));
    assign rx_edge   = uart_rx_rdy & ~rx_rdy_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_tx), .pop(tx_pop), .din(bus.wdata[7:0]),
        .dout(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_edge), .pop(rx_pop), .din(uart_rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            uart_tx_data <= '0;
        end else begin
            state <= state_nx;
            if (tx_pop) uart_tx_data <= tx_dout;
        end
    end

    always_comb begin
        state_nx = state;
        tx_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop   = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD:      state_nx = WAIT_BUSY;
            WAIT_BUSY: if (uart_busy) state_nx = WAIT_DONE;
            WAIT_DONE: if (!uart_busy) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    assign uart_send = (state == LOAD) || (state == WAIT_BUSY);

    assign txe    = tx_empty & (state == IDLE);
    assign rxne   = ~rx_empty;
    assign status = {rxovf, txovf, txe, rxne, tx_full};
    assign irq    = (rxne & ctrl[0]) | (txe & ctrl[1]);

    // A pop in the same cycle frees a slot, so only a push against a full FIFO
    // with no concurrent pop counts as an overflow.
    assign txovf_set = wr_tx & tx_full & ~tx_pop;
    assign rxovf_set = rx_edge & rx_full & ~rx_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_rdy_q <= 1'b0;
            ctrl     <= '0;
            txovf    <= 1'b0;
            rxovf    <= 1'b0;
        end else begin
            rx_rdy_q <= uart_rx_rdy;
            if (wr_ctrl) ctrl <= bus.wdata[1:0];
            txovf <= txovf_set | (txovf & ~(wr_status & bus.wdata[ST_TXOVF]));
            rxovf <= rxovf_set | (rxovf & ~(wr_status & bus.wdata[ST_RXOVF]));
        end
    end

    always_comb begin
        rd_mux = '0;
        case (word_addr)
            ADDR_W'(REG_RXDATA): rd_mux = rx_empty ? 32'h0 : {24'h0, rx_dout};
            ADDR_W'(REG_STATUS): rd_mux = {27'h0, status};
            ADDR_W'(REG_CTRL):   rd_mux = {30'h0, ctrl};
            default:             rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= bus.re;
            if (bus.re) bus.rdata <= rd_mux;
        end
    end

    assign unused_ok = ^{bus.wdata[31:8], bus.addr[1:0], tx_count, rx_count};
endmodule
